redmule_tcdm_arbiter: RTL and testbench
=======================================

# redmule_tcdm_arbiter

Time-multiplexes the MP 32-bit TCDM data-memory ports between the RedMulE wide port (DW = 32·MP bits) and the core's narrow 32-bit data port. Only one requester owns the memory side in any cycle. Ownership of a stalled request is held until the memory grants it. Responses are routed back in order through an owner queue. The block sits between the `redmule_complex` TCDM/core data ports and the dummy or real data memory.

## Interface
- `MP`, 4: number of 32-bit memory ports; power of two, ≥1.
- `OUTST`, 4: maximum outstanding transactions (owner-queue depth); power of two, ≥2.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset; synchronous and active-high.
- `w_req_i`, `w_wen_i` (1 = read)  in  1 each; `w_add_i`  in  32; `w_be_i`  in  4·MP; `w_data_i`  in  32·MP: wide request.
- `w_gnt_o`  out  1; `w_r_valid_o`  out  1; `w_r_data_o`  out  32·MP: wide grant and response.
- `n_req_i`, `n_wen_i`  in  1 each; `n_add_i`  in  32; `n_be_i`  in  4; `n_data_i`  in  32: narrow (core) request.
- `n_gnt_o`, `n_r_valid_o`  out  1 each; `n_r_data_o`  out  32: narrow grant and response.
- `m_req_o`, `m_wen_o`  out  MP each; `m_add_o`  out  MP×32; `m_be_o`  out  MP×4; `m_data_o`  out  MP×32: memory requests.
- `m_gnt_i`, `m_r_valid_i`  in  MP each; `m_r_data_i`  in  MP×32: memory grants and responses.
- `err_o`  out  1: sticky flag for an unexpected response.

## Operation
- FSM states: `ARB`, `HOLD_N`, `HOLD_W`. Round-robin pointer `last_o` ∈ {N, W}.
- **ARB**
  - The winner is the only requester when one requests. When both request, the winner is the one ≠ `last_o`.
  - The winner drives the memory side in the same cycle.
  - Granted → push its entry into the queue, set `last_o` = winner, stay in `ARB`.
  - Not granted → go to `HOLD_N` or `HOLD_W`.
- **HOLD_x**: only requester x is forwarded; the other's `gnt` is 0. On grant → push, set `last_o` = x, return to `ARB`.
- **Wide request**
  - Port ii gets `m_req_o[ii]`=1 and `m_add_o[ii]` = `w_add_i` + 4·ii, plus the ii-th 4-bit slice of be and 32-bit slice of data.
  - `w_gnt_o` = &`m_gnt_i` (all-or-nothing). The request is re-presented on all ports until every port grants in the same cycle.
- **Narrow request**
  - sel = `n_add_i`[clog2(MP)+1:2] (sel = 0 when MP = 1).
  - Only `m_req_o[sel]`=1, carrying `n_add_i`, `n_be_i` and `n_data_i`. `n_gnt_o` = `m_gnt_i[sel]`.
- **Owner queue**: entries are {owner, sel}. Push on every grant, reads and writes alike.
  - Head W: `w_r_valid_o` = &`m_r_valid_i`, `w_r_data_o` = concatenation of `m_r_data_i` with port 0 at the LSBs.
  - Head N: `n_r_valid_o` = `m_r_valid_i[sel]`, `n_r_data_o` = `m_r_data_i[sel]`.
  - Pop when the routed `r_valid` is 1.
  - Any `m_r_valid_i` bit high while the queue is empty sets `err_o`. The response is dropped. Only reset clears `err_o`.
- **Full queue**: all `m_req_o` = 0 and both grants = 0, even if a pop occurs in the same cycle. The FSM state is unchanged.
- **Simultaneous push and pop** when not full: both happen and the count is unchanged.

## Timing
- Request path is combinational: req → `m_req_o`, and `m_gnt_i` → `w_gnt_o`/`n_gnt_o`, in the same cycle.
- Response path is combinational: `m_r_valid_i`/`m_r_data_i` → routed response, in the same cycle. The block adds no latency.
- FSM, `last_o`, queue and `err_o` update on the rising edge.
- Reset values:
  - State `ARB`, `last_o` = W (narrow wins the first tie), queue empty, `err_o` = 0.
  - All `*_gnt_o`, `*_r_valid_o` and `m_req_o` = 0; data outputs = 0.
- Reset mid-operation: the queue is flushed. Responses to transactions granted before reset arrive with an empty queue and set `err_o`.
- Requesters keep req and payload stable until granted. A request dropped in `HOLD_x` returns the FSM to `ARB` next cycle with no push.

## Structure
- `redmule_pkg` gets `arb_owner_e` {OWN_N, OWN_W}, `arb_state_e` {ARB, HOLD_N, HOLD_W}, and the packed `arb_entry_t` {owner, sel}.
- Sub-module `redmule_tcdm_arb_queue`: synchronous FIFO of `arb_entry_t`, depth `OUTST`.
  - Push, pop, head, `full_o` and `empty_o`.
  - Flushed by `rst_i`.

## Test plan
- **Narrow read alone**: MP=4, `n_add_i`=0x1C01_0008, one-cycle memory → only `m_req_o[2]`=1, `n_gnt_o`=1 in the same cycle. The next cycle gives `n_r_valid_o`=1 with `m_r_data_i[2]`.
- **Wide write alone**: `w_add_i`=0x1C01_0100 → `m_add_o` = 0x…100/104/108/10C with matching be/data slices. With `m_gnt_i`=4'b1011, `w_gnt_o`=0. With 4'b1111 in the next cycle, `w_gnt_o`=1 and exactly one push occurs.
- **Both request every cycle for 8 cycles, no stalls** → grants alternate N, W, N, W… starting with N after reset. Responses are routed in order.
- **Stall hold**: narrow request with `m_gnt_i[sel]`=0 for 3 cycles while `w_req_i`=1 → `w_gnt_o` stays 0 and the FSM is in `HOLD_N`. The narrow request is granted in cycle 4, then the wide request in cycle 5.
- **Full queue**: withhold `m_r_valid_i`, issue 4 grants → the 5th request sees `gnt`=0 and `m_req_o`=0. One response frees a slot, and the request is granted the following cycle.
- **Error**: pulse `m_r_valid_i[0]` with the queue empty → `err_o`=1 from the next cycle. It stays set until `rst_i`; after reset, `err_o`=0 and the queue is empty.

Source files
------------

// File: rtl/redmule_pkg.sv
// redmule_pkg: shared types for the RedMulE TCDM arbiter
package redmule_pkg;

   localparam int unsigned ARB_SEL_W = 8;

   typedef enum logic {OWN_N, OWN_W} arb_owner_e;

   typedef enum logic [1:0] {ARB, HOLD_N, HOLD_W} arb_state_e;

   typedef struct packed {
      arb_owner_e             owner;
      logic [ARB_SEL_W-1:0]   sel;
   } arb_entry_t;

endpackage

// File: rtl/redmule_tcdm_arb_queue.sv
// redmule_tcdm_arb_queue: in-order owner FIFO of outstanding memory transactions
module redmule_tcdm_arb_queue
   import redmule_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  arb_entry_t data_i,
   input  logic       pop_i,
   output arb_entry_t head_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   arb_entry_t    mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;

   assign full_o  = cnt == (AW+1)'(DEPTH);
   assign empty_o = cnt == '0;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem[rp];

   // pointers and occupancy; a flush only needs these cleared
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // entry storage, written at the tail
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wp] <= data_i;
   end

endmodule

// File: rtl/redmule_tcdm_arbiter.sv
// redmule_tcdm_arbiter: shares the MP TCDM ports between the wide RedMulE port and the narrow core port
module redmule_tcdm_arbiter
   import redmule_pkg::*;
#(
   parameter int unsigned MP    = 4,
   parameter int unsigned OUTST = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  w_req_i,
   input  logic                  w_wen_i,
   input  logic [31:0]           w_add_i,
   input  logic [4*MP-1:0]       w_be_i,
   input  logic [32*MP-1:0]      w_data_i,
   output logic                  w_gnt_o,
   output logic                  w_r_valid_o,
   output logic [32*MP-1:0]      w_r_data_o,
   input  logic                  n_req_i,
   input  logic                  n_wen_i,
   input  logic [31:0]           n_add_i,
   input  logic [3:0]            n_be_i,
   input  logic [31:0]           n_data_i,
   output logic                  n_gnt_o,
   output logic                  n_r_valid_o,
   output logic [31:0]           n_r_data_o,
   output logic [MP-1:0]         m_req_o,
   output logic [MP-1:0]         m_wen_o,
   output logic [MP-1:0][31:0]   m_add_o,
   output logic [MP-1:0][3:0]    m_be_o,
   output logic [MP-1:0][31:0]   m_data_o,
   input  logic [MP-1:0]         m_gnt_i,
   input  logic [MP-1:0]         m_r_valid_i,
   input  logic [MP-1:0][31:0]   m_r_data_i,
   output logic                  err_o
);

   localparam int unsigned SW = (MP > 1) ? $clog2(MP) : 1;

   arb_state_e    state_q, state_d;
   arb_owner_e    last_q;
   arb_entry_t    head, entry;
   logic [SW-1:0] sel_n;
   logic          arb_n, serve_n, serve_w, push, pop, full, empty;

   assign sel_n   = (MP > 1) ? n_add_i[SW+1:2] : '0;
   // on a tie the narrow port wins unless it was the last one served
   assign arb_n   = n_req_i && (!w_req_i || last_q == OWN_W);
   assign serve_n = !full && (state_q == HOLD_N ? n_req_i : state_q == ARB && arb_n);
   assign serve_w = !full && (state_q == HOLD_W ? w_req_i : state_q == ARB && w_req_i && !arb_n);
   assign w_gnt_o = serve_w && &m_gnt_i;
   assign n_gnt_o = serve_n && m_gnt_i[sel_n];
   assign push    = w_gnt_o || n_gnt_o;
   assign pop     = w_r_valid_o || n_r_valid_o;
   assign entry   = '{owner: serve_w ? OWN_W : OWN_N, sel: serve_w ? '0 : ARB_SEL_W'(sel_n)};

   redmule_tcdm_arb_queue #(
      .DEPTH(OUTST)
   ) i_queue (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (push),
      .data_i (entry),
      .pop_i  (pop),
      .head_o (head),
      .full_o (full),
      .empty_o(empty)
   );

   // a stalled request keeps ownership; grants and dropped requests fall back to arbitration
   always_comb begin
      state_d = state_q;
      if (!full) state_d = push ? ARB : serve_n ? HOLD_N : serve_w ? HOLD_W : ARB;
   end

   // fan the owning request out to the memory ports
   always_comb begin
      m_req_o  = '0;
      m_wen_o  = '0;
      m_add_o  = '0;
      m_be_o   = '0;
      m_data_o = '0;
      for (int i = 0; i < MP; i++) begin
         if (serve_w) begin
            m_req_o[i]  = 1'b1;
            m_wen_o[i]  = w_wen_i;
            m_add_o[i]  = w_add_i + 32'(4 * i);
            m_be_o[i]   = w_be_i[4*i +: 4];
            m_data_o[i] = w_data_i[32*i +: 32];
         end else if (serve_n && sel_n == SW'(i)) begin
            m_req_o[i]  = 1'b1;
            m_wen_o[i]  = n_wen_i;
            m_add_o[i]  = n_add_i;
            m_be_o[i]   = n_be_i;
            m_data_o[i] = n_data_i;
         end
      end
   end

   // route memory responses to the owner at the head of the queue
   always_comb begin
      w_r_valid_o = 1'b0;
      n_r_valid_o = 1'b0;
      w_r_data_o  = '0;
      n_r_data_o  = '0;
      if (!empty && head.owner == OWN_W) begin
         w_r_valid_o = &m_r_valid_i;
         w_r_data_o  = w_r_valid_o ? m_r_data_i : '0;
      end else if (!empty) begin
         for (int i = 0; i < MP; i++) begin
            if (head.sel == ARB_SEL_W'(i)) begin
               n_r_valid_o = m_r_valid_i[i];
               n_r_data_o  = m_r_valid_i[i] ? m_r_data_i[i] : '0;
            end
         end
      end
   end

   // FSM state, round-robin pointer and sticky unexpected-response flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ARB;
         last_q  <= OWN_W;
         err_o   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (push) last_q <= entry.owner;
         if (empty && |m_r_valid_i) err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_redmule_tcdm_arbiter.sv
// tb_redmule_tcdm_arbiter: randomized scoreboard bench for the TCDM arbiter
module tb_redmule_tcdm_arbiter;

   localparam int MP    = 4;
   localparam int OUTST = 4;
   localparam int CW    = 32 * MP;

   logic                clk_i = 1'b0;
   logic                rst_i;
   logic                w_req_i, w_wen_i, w_gnt_o, w_r_valid_o;
   logic [31:0]         w_add_i;
   logic [4*MP-1:0]     w_be_i;
   logic [CW-1:0]       w_data_i, w_r_data_o;
   logic                n_req_i, n_wen_i, n_gnt_o, n_r_valid_o;
   logic [31:0]         n_add_i, n_data_i, n_r_data_o;
   logic [3:0]          n_be_i;
   logic [MP-1:0]       m_req_o, m_wen_o, m_gnt_i, m_r_valid_i;
   logic [MP-1:0][31:0] m_add_o, m_data_o, m_r_data_i;
   logic [MP-1:0][3:0]  m_be_o;
   logic                err_o;

   always #5 clk_i = ~clk_i;

   redmule_tcdm_arbiter #(.MP(MP), .OUTST(OUTST)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .w_req_i(w_req_i), .w_wen_i(w_wen_i), .w_add_i(w_add_i), .w_be_i(w_be_i), .w_data_i(w_data_i),
      .w_gnt_o(w_gnt_o), .w_r_valid_o(w_r_valid_o), .w_r_data_o(w_r_data_o),
      .n_req_i(n_req_i), .n_wen_i(n_wen_i), .n_add_i(n_add_i), .n_be_i(n_be_i), .n_data_i(n_data_i),
      .n_gnt_o(n_gnt_o), .n_r_valid_o(n_r_valid_o), .n_r_data_o(n_r_data_o),
      .m_req_o(m_req_o), .m_wen_o(m_wen_o), .m_add_o(m_add_o), .m_be_o(m_be_o), .m_data_o(m_data_o),
      .m_gnt_i(m_gnt_i), .m_r_valid_i(m_r_valid_i), .m_r_data_i(m_r_data_i),
      .err_o(err_o)
   );

   typedef struct {bit w; logic [CW-1:0] d;} exp_t;
   typedef struct {bit w; int sel;} pend_t;

   exp_t          exp_q[$];
   pend_t         pend[$];
   int            total = 0, bad = 0;
   int            p_n, p_w, p_r, p_g;
   bit            g_use, inj, exp_err;
   logic [MP-1:0] g_val;
   int            lock, last;

   task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // response monitor: every routed response must match the oldest expected one
   always @(negedge clk_i) begin : mon
      exp_t e;
      #2;
      if (n_r_valid_o || w_r_valid_o) begin
         if (exp_q.size() == 0) chk("resp_unexpected", {w_r_valid_o, n_r_valid_o}, 0);
         else begin
            e = exp_q.pop_front();
            chk("resp_owner", {w_r_valid_o, n_r_valid_o}, e.w ? 2'b10 : 2'b01);
            chk("resp_data", e.w ? w_r_data_o : CW'(n_r_data_o), e.d);
         end
      end
   end

   task automatic set_n(input logic [31:0] a, input logic wen);
      n_req_i  = 1'b1;
      n_add_i  = a;
      n_wen_i  = wen;
      n_be_i   = 4'($urandom);
      n_data_i = $urandom;
   endtask

   task automatic set_w(input logic [31:0] a, input logic wen);
      w_req_i  = 1'b1;
      w_add_i  = a;
      w_wen_i  = wen;
      w_be_i   = 16'($urandom);
      w_data_i = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // one clock cycle, entered and left on a falling edge
   task automatic step();
      int                  win, sel;
      bit                  gnt, full, resp, injd;
      pend_t               h;
      exp_t                e;
      logic [MP-1:0]       exp_req;
      logic [MP-1:0][31:0] exp_add;
      chk("resp_missing", exp_q.size(), 0);
      if (!n_req_i && $urandom_range(99) < p_n) set_n($urandom & 32'hFFFF_FFFC, 1'($urandom));
      if (!w_req_i && $urandom_range(99) < p_w) set_w($urandom & 32'hFFFF_FFF0, 1'($urandom));
      m_gnt_i = g_use ? g_val : ($urandom_range(99) < p_g ? '1 : MP'($urandom));
      m_r_valid_i = '0;
      for (int i = 0; i < MP; i++) m_r_data_i[i] = $urandom;
      resp = 0;
      injd = 0;
      if (pend.size() > 0 && $urandom_range(99) < p_r) begin
         h = pend[0];
         resp = 1;
         e.w = h.w;
         e.d = '0;
         if (h.w) begin
            m_r_valid_i = '1;
            e.d = m_r_data_i;
         end else begin
            m_r_valid_i[h.sel] = 1'b1;
            e.d[31:0] = m_r_data_i[h.sel];
         end
         exp_q.push_back(e);
      end else if (inj && pend.size() == 0) begin
         m_r_valid_i[0] = 1'b1;
         injd = 1;
      end
      #1;
      sel  = int'(n_add_i[3:2]);
      full = pend.size() >= OUTST;
      win  = 0;
      if (!full) begin
         if (lock == 1) win = n_req_i ? 1 : 0;
         else if (lock == 2) win = w_req_i ? 2 : 0;
         else if (n_req_i && w_req_i) win = (last == 2) ? 1 : 2;
         else if (n_req_i) win = 1;
         else if (w_req_i) win = 2;
      end
      gnt = (win == 1 && m_gnt_i[sel]) || (win == 2 && &m_gnt_i);
      exp_req = (win == 2) ? '1 : (win == 1) ? MP'(1 << sel) : '0;
      chk("m_req", m_req_o, exp_req);
      chk("n_gnt", n_gnt_o, win == 1 && gnt);
      chk("w_gnt", w_gnt_o, win == 2 && gnt);
      chk("err", err_o, exp_err);
      if (win == 1) begin
         chk("n_add", m_add_o[sel], n_add_i);
         chk("n_payload", {m_wen_o[sel], m_be_o[sel], m_data_o[sel]}, {n_wen_i, n_be_i, n_data_i});
      end
      if (win == 2) begin
         for (int i = 0; i < MP; i++) exp_add[i] = w_add_i + 32'(4 * i);
         chk("w_add", m_add_o, exp_add);
         chk("w_data", m_data_o, w_data_i);
         chk("w_be_wen", {m_be_o, m_wen_o}, {w_be_i, {MP{w_wen_i}}});
      end
      @(posedge clk_i);
      if (resp) void'(pend.pop_front());
      if (injd) exp_err = 1;
      if (!full) begin
         if (gnt) begin
            pend.push_back('{w: win == 2, sel: sel});
            last = win;
            lock = 0;
         end else lock = win;
      end
      @(negedge clk_i);
      if (gnt && win == 1) n_req_i = 1'b0;
      if (gnt && win == 2) w_req_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_i       = 1'b1;
      n_req_i     = 1'b0;
      w_req_i     = 1'b0;
      m_gnt_i     = '0;
      m_r_valid_i = '0;
      for (int i = 0; i < MP; i++) m_r_data_i[i] = $urandom | 32'h1;
      pend.delete();
      exp_q.delete();
      lock    = 0;
      last    = 2;
      exp_err = 0;
      inj     = 0;
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      chk("rst_m_req", m_req_o, 0);
      chk("rst_gnt", {n_gnt_o, w_gnt_o}, 0);
      chk("rst_r_valid", {n_r_valid_o, w_r_valid_o}, 0);
      chk("rst_err", err_o, 0);
      chk("rst_w_r_data", w_r_data_o, 0);
      chk("rst_n_r_data", n_r_data_o, 0);
      rst_i = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic drain();
      p_n   = 0;
      p_w   = 0;
      p_r   = 100;
      g_use = 1;
      g_val = '1;
      for (int k = 0; k < 40 && (pend.size() > 0 || n_req_i || w_req_i); k++) step();
      chk("drain", pend.size() + int'(n_req_i) + int'(w_req_i), 0);
   endtask

   initial begin
      {w_wen_i, n_wen_i} = '0;
      w_add_i  = '0;
      w_be_i   = '0;
      w_data_i = '0;
      n_add_i  = '0;
      n_be_i   = '0;
      n_data_i = '0;
      p_g      = 100;
      @(negedge clk_i);
      do_reset();

      // narrow read alone, then its response
      p_n = 0; p_w = 0; p_r = 0; g_use = 1; g_val = '1;
      set_n(32'h1C01_0008, 1'b1);
      step();
      p_r = 100;
      step();

      // wide write: partial grant stalls, full grant next cycle
      p_r = 0;
      set_w(32'h1C01_0100, 1'b0);
      g_val = 4'b1011;
      step();
      g_val = '1;
      step();
      p_r = 100;
      step();

      // both request every cycle without stalls
      do_reset();
      p_n = 100; p_w = 100; p_r = 100; g_use = 1; g_val = '1;
      repeat (8) step();
      drain();

      // narrow stalled three cycles while wide waits
      do_reset();
      p_n = 0; p_w = 0; p_r = 0; g_use = 1;
      set_n(32'h1C01_0004, 1'b1);
      set_w(32'h1C01_0200, 1'b1);
      g_val = 4'b1101;
      repeat (3) step();
      g_val = '1;
      repeat (2) step();
      drain();

      // owner queue fills, one response frees a slot
      do_reset();
      p_n = 100; p_w = 0; p_r = 0; g_use = 1; g_val = '1;
      repeat (5) step();
      p_r = 100;
      repeat (2) step();
      drain();

      // randomized traffic with stalls and response gaps
      g_use = 0; p_n = 40; p_w = 40; p_r = 50; p_g = 70;
      repeat (600) step();
      drain();

      // unexpected response sets the sticky error until reset
      inj = 1;
      step();
      inj = 0;
      repeat (3) step();
      do_reset();
      p_n = 0; p_w = 0; p_r = 0; g_use = 1; g_val = '1;
      set_n(32'h1C01_000C, 1'b1);
      step();
      p_r = 100;
      step();
      step();
      chk("final_queue", exp_q.size() + pend.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
